// File: rtl/rv32i_sequencer_if.sv
// Instruction/data memory handshake bundle for the RV32I multi-cycle sequencer.
// master = sequencer side, slave = memory side.
interface rv32i_sequencer_if #(
    parameter int XLEN = 32
);
    logic            o_im_req;
    logic [XLEN-1:0] o_im_addr;
    logic            i_im_ack;
    logic [XLEN-1:0] i_im_rdata;
    logic            o_dm_req;
    logic            i_dm_ack;

    modport master (
        output o_im_req, o_im_addr, o_dm_req,
        input  i_im_ack, i_im_rdata, i_dm_ack
    );

    modport slave (
        input  o_im_req, o_im_addr, o_dm_req,
        output i_im_ack, i_im_rdata, i_dm_ack
    );
endinterface

// File: rtl/rv32i_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
// Define RV32I_ILLEGAL_TRAP_EN to halt on unlisted opcodes (else they retire as NOPs).
module rv32i_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    rv32i_sequencer_if.master     bus,
    output logic [XLEN-1:0]       o_ir,
    input  logic [6:0]            i_opcode,
    output logic                  o_ex_en,
    output logic                  o_rf_we,
    input  logic                  i_branch_taken,
    input  logic [XLEN-1:0]       i_target,
    output logic [XLEN-1:0]       o_pc,
    output logic [31:0]           o_instret,
    output logic                  o_trap
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEMORY,
        WRITEBACK,
        HALT
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [31:0]     instret_q, instret_d;

    logic is_load, is_store, is_branch, is_alu, is_jump;
    logic pc_upd, ir_ld, take;
    logic im_req, dm_req, ex_en, rf_we;

    // Opcode classes seen by the sequencer.
    always_comb begin
        is_load   = (i_opcode == OP_LOAD);
        is_store  = (i_opcode == OP_STORE);
        is_branch = (i_opcode == OP_BRANCH);
        is_jump   = (i_opcode == OP_JAL) || (i_opcode == OP_JALR);
        is_alu    = (i_opcode == OP_R) || (i_opcode == OP_I) ||
                    (i_opcode == OP_LUI) || (i_opcode == OP_AUIPC);
    end

    // Next-state and strobe generation.
    always_comb begin
        state_d = state_q;
        pc_upd  = 1'b0;
        ir_ld   = 1'b0;
        im_req  = 1'b0;
        dm_req  = 1'b0;
        ex_en   = 1'b0;
        rf_we   = 1'b0;
        unique case (state_q)
            FETCH: begin
                im_req = 1'b1;
                if (bus.i_im_ack) begin
                    ir_ld   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = EXECUTE;
            end
            EXECUTE: begin
                ex_en = 1'b1;
                unique case (1'b1)
                    is_load, is_store: state_d = MEMORY;
                    is_alu, is_jump:   state_d = WRITEBACK;
                    is_branch: begin
                        pc_upd  = 1'b1;
                        state_d = FETCH;
                    end
                    default: begin
`ifdef RV32I_ILLEGAL_TRAP_EN
                        state_d = HALT;
`else
                        pc_upd  = 1'b1;
                        state_d = FETCH;
`endif
                    end
                endcase
            end
            MEMORY: begin
                dm_req = 1'b1;
                if (bus.i_dm_ack) begin
                    if (is_load) begin
                        state_d = WRITEBACK;
                    end else begin
                        pc_upd  = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            WRITEBACK: begin
                rf_we   = 1'b1;
                pc_upd  = 1'b1;
                state_d = FETCH;
            end
            HALT: begin
`ifdef RV32I_ILLEGAL_TRAP_EN
                state_d = HALT;
`else
                state_d = FETCH;
`endif
            end
            default: state_d = FETCH;
        endcase
    end

    // Datapath next values: PC redirect, retire counter, instruction latch.
    always_comb begin
        take      = is_jump || (is_branch && i_branch_taken);
        pc_d      = pc_q;
        instret_d = instret_q;
        ir_d      = ir_q;
        if (pc_upd) begin
            pc_d      = take ? i_target : pc_q + XLEN'(4);
            instret_d = instret_q + 32'd1;
        end
        if (ir_ld) begin
            ir_d = bus.i_im_rdata;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
        end
    end

    // Strobes are masked by reset so they drop without waiting for a clock.
    always_comb begin
        bus.o_im_req  = im_req & ~rst;
        bus.o_dm_req  = dm_req & ~rst;
        bus.o_im_addr = pc_q;
        o_ex_en       = ex_en & ~rst;
        o_rf_we       = rf_we & ~rst;
        o_pc          = pc_q;
        o_ir          = ir_q;
        o_instret     = instret_q;
`ifdef RV32I_ILLEGAL_TRAP_EN
        o_trap        = (state_q == HALT) & ~rst;
`else
        o_trap        = 1'b0;
`endif
    end

endmodule

// File: tb/tb_rv32i_sequencer.sv
// Self-checking bench for rv32i_sequencer: directed scenarios plus random
// instruction streams compared against an instruction-level timing model.
module tb_rv32i_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] o_ir;
    logic [6:0]  i_opcode;
    logic        o_ex_en;
    logic        o_rf_we;
    logic        i_branch_taken;
    logic [31:0] i_target;
    logic [31:0] o_pc;
    logic [31:0] o_instret;
    logic        o_trap;

    rv32i_sequencer_if #(.XLEN(32)) bus ();

    rv32i_sequencer #(
        .XLEN     (32),
        .RESET_PC (32'h100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .o_ir           (o_ir),
        .i_opcode       (i_opcode),
        .o_ex_en        (o_ex_en),
        .o_rf_we        (o_rf_we),
        .i_branch_taken (i_branch_taken),
        .i_target       (i_target),
        .o_pc           (o_pc),
        .o_instret      (o_instret),
        .o_trap         (o_trap)
    );

    assign i_opcode = o_ir[6:0];

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instret;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // 0 load, 1 store, 2 branch, 3 alu/upper, 4 jump, 5 unlisted
    function automatic int op_class(input logic [6:0] op);
        case (op)
            7'b0000011: return 0;
            7'b0100011: return 1;
            7'b1100011: return 2;
            7'b0110011, 7'b0010011,
            7'b0110111, 7'b0010111: return 3;
            7'b1101111, 7'b1100111: return 4;
            default: return 5;
        endcase
    endfunction

    function automatic bit trap_build();
`ifdef RV32I_ILLEGAL_TRAP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Runs one instruction from FETCH; imw/dmw are acknowledge wait cycles.
    task automatic run(input string tag, input logic [31:0] instr,
                       input int imw, input int dmw,
                       input logic tk, input logic [31:0] tgt);
        int c, base, nim, ndm, nrf, nex, rf_at, k, d, cyc;
        bit done, onehot_ok, halts;
        c = op_class(instr[6:0]);
        halts = (c == 5) && trap_build();
        i_branch_taken = tk;
        i_target = tgt;
        chk({tag, ".addr"}, bus.o_im_addr, m_pc);
        nim = 0; ndm = 0; nrf = 0; nex = 0; rf_at = 0;
        k = 0; d = 0; cyc = 0; done = 0; onehot_ok = 1;
        while (!done && cyc < 64) begin
            if ($countones({bus.o_im_req, o_ex_en, bus.o_dm_req, o_rf_we}) > 1)
                onehot_ok = 0;
            if (bus.o_im_req) nim++;
            if (bus.o_dm_req) ndm++;
            if (o_ex_en) nex++;
            if (o_rf_we) begin
                nrf++;
                rf_at = cyc + 1;
            end
            if (bus.o_im_req) begin
                bus.i_im_ack   = (k == imw);
                bus.i_im_rdata = (k == imw) ? instr : $urandom;
                k++;
            end else begin
                bus.i_im_ack   = 1'($urandom);
                bus.i_im_rdata = $urandom;
            end
            if (bus.o_dm_req) begin
                bus.i_dm_ack = (d == dmw);
                d++;
            end else begin
                bus.i_dm_ack = 1'($urandom);
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            done = (nex > 0 && bus.o_im_req) || o_trap;
        end
        bus.i_im_ack = 1'b0;
        bus.i_dm_ack = 1'b0;
        case (c)
            0: base = 5 + dmw;
            1: base = 4 + dmw;
            2: base = 3;
            3, 4: base = 4;
            default: base = 3;
        endcase
        base += imw;
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".cycles"}, cyc, base);
        chk({tag, ".im_cycles"}, nim, imw + 1);
        chk({tag, ".ex_cnt"}, nex, 1);
        chk({tag, ".dm_cycles"}, ndm, (c <= 1) ? dmw + 1 : 0);
        chk({tag, ".rf_cnt"}, nrf, (c == 0 || c == 3 || c == 4) ? 1 : 0);
        if (nrf == 1) chk({tag, ".rf_at"}, rf_at, base);
        chk({tag, ".onehot"}, 32'(onehot_ok), 32'd1);
        chk({tag, ".ir"}, o_ir, instr);
        if (!halts) begin
            if (c == 4 || (c == 2 && tk)) m_pc = tgt;
            else m_pc = m_pc + 32'd4;
            m_instret = m_instret + 32'd1;
        end
        chk({tag, ".pc"}, o_pc, m_pc);
        chk({tag, ".instret"}, o_instret, m_instret);
        chk({tag, ".trap"}, 32'(o_trap), 32'(halts));
    endtask

    logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b1100011,
                                  7'b0110011, 7'b0010011, 7'b0110111,
                                  7'b0010111, 7'b1101111, 7'b1100111};

    initial begin
        logic [31:0] r;
        int wait_n;
        rst = 1'b1;
        bus.i_im_ack = 1'b0;
        bus.i_im_rdata = '0;
        bus.i_dm_ack = 1'b0;
        i_branch_taken = 1'b0;
        i_target = '0;
        #1;
        chk("rst.pc", o_pc, 32'h100);
        chk("rst.ir", o_ir, 32'h0);
        chk("rst.instret", o_instret, 32'h0);
        chk("rst.trap", 32'(o_trap), 32'h0);
        chk("rst.strobes",
            32'({bus.o_im_req, o_ex_en, bus.o_dm_req, o_rf_we}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst.im_req", 32'(bus.o_im_req), 32'h1);
        m_pc = 32'h100;
        m_instret = 0;
        @(negedge clk);

        run("addi", 32'h00500093, 0, 0, 1'b0, 32'h0);
        run("load_w3", 32'h0000A103, 0, 3, 1'b0, 32'h0);
        run("beq_tk", 32'h00000063, 0, 0, 1'b1, 32'h200);
        run("beq_nt", 32'h00000063, 1, 0, 1'b0, 32'h300);
        run("store", 32'h00112023, 2, 1, 1'b1, 32'h400);
        run("jal_wrap", 32'h0000006F, 0, 0, 1'b0, 32'hFFFF_FFFC);

        bus.i_im_ack = 1'b0;
        force dut.instret_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.instret_q;
        m_instret = 32'hFFFF_FFFF;
        chk("preset.instret", o_instret, 32'hFFFF_FFFF);
        run("add_wrap", 32'h002081B3, 0, 0, 1'b0, 32'h0);
        chk("wrap.pc_zero", o_pc, 32'h0);
        chk("wrap.instret_zero", o_instret, 32'h0);

        for (int i = 0; i < 30; i++) begin
            r = $urandom;
            wait_n = $urandom_range(0, 3);
            run($sformatf("rnd%0d", i),
                {r[31:7], legal_ops[$urandom_range(0, 8)]},
                $urandom_range(0, 2), wait_n, 1'($urandom),
                $urandom & 32'hFFFF_FFFC);
        end

        bus.i_im_rdata = 32'h0000A103;
        bus.i_im_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_im_ack = 1'b0;
        for (int i = 0; i < 8 && !bus.o_dm_req; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid.dm_req_before", 32'(bus.o_dm_req), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid.dm_req_drop", 32'(bus.o_dm_req), 32'h0);
        chk("mid.pc", o_pc, 32'h100);
        chk("mid.instret", o_instret, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.i_dm_ack = 1'b1;
        #1;
        chk("mid.im_req", 32'(bus.o_im_req), 32'h1);
        chk("mid.addr", bus.o_im_addr, 32'h100);
        @(posedge clk);
        @(negedge clk);
        bus.i_dm_ack = 1'b0;
        chk("mid.stray_ack.im_req", 32'(bus.o_im_req), 32'h1);
        chk("mid.stray_ack.dm_req", 32'(bus.o_dm_req), 32'h0);
        chk("mid.stray_ack.pc", o_pc, 32'h100);
        m_pc = 32'h100;
        m_instret = 0;

        run("illegal", 32'h0000007F, 0, 0, 1'b0, 32'h0);
        if (trap_build()) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                @(negedge clk);
            end
            chk("halt.trap", 32'(o_trap), 32'h1);
            chk("halt.pc", o_pc, 32'h100);
            chk("halt.strobes",
                32'({bus.o_im_req, o_ex_en, bus.o_dm_req, o_rf_we}), 32'h0);
        end else begin
            run("after_illegal", 32'h00500093, 0, 0, 1'b0, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
